// File: rtl/csa_sub_43bit_seq.sv
// Multicycle unsigned subtractor: A - B computed as A + ~B + 1, one carry-select
// slice per clock. The top slice is narrower when WIDTH is not a multiple of SLICE.
// Valid/ready on both sides; o_ready is decoded only from registered state.

module csa_sub_43bit_seq #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned SLICE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    // Derived geometry; not meant to be overridden.
    localparam int unsigned NSLICE = (WIDTH + SLICE - 1) / SLICE;
    localparam int unsigned LAST_W = WIDTH - (NSLICE - 1) * SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NSLICE - 1);
    localparam logic [SLICE-1:0] FULL_MASK = {SLICE{1'b1}};
    localparam logic [SLICE-1:0] LAST_MASK = FULL_MASK >> (SLICE - LAST_W);

    // Reject illegal geometry at elaboration.
    if (SLICE < 2 || SLICE > 8) begin : gen_bad_slice
        $error("SLICE must be in 2..8");
    end
    if (WIDTH < SLICE + 1) begin : gen_bad_width
        $error("WIDTH must be at least SLICE+1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;          // holds ~B
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             valid_q, valid_d;

    // Slice datapath signals
    logic             is_last;
    int unsigned      shamt;
    logic [SLICE-1:0] slice_mask;
    logic [WIDTH-1:0] a_win, nb_win;
    logic [SLICE-1:0] a_s, nb_s;
    logic [SLICE:0]   sum0, sum1, sel;
    logic             cout;
    logic [WIDTH-1:0] put_mask, put_bits;

    // Current slice: both carry-in candidates in parallel, picked by the stored carry.
    always_comb begin
        is_last    = (idx_q == LAST_IDX);
        shamt      = 32'(idx_q) * SLICE;
        slice_mask = is_last ? LAST_MASK : FULL_MASK;

        a_win  = a_q >> shamt;
        nb_win = nb_q >> shamt;
        a_s    = a_win[SLICE-1:0] & slice_mask;
        nb_s   = nb_win[SLICE-1:0] & slice_mask;

        sum0 = {1'b0, a_s} + {1'b0, nb_s};
        sum1 = {1'b0, a_s} + {1'b0, nb_s} + (SLICE + 1)'(1);
        sel  = carry_q ? sum1 : sum0;

        // Narrow top slice: its carry-out sits just above its LAST_W bits.
        cout = is_last ? sel[LAST_W] : sel[SLICE];

        put_mask = WIDTH'(slice_mask) << shamt;
        put_bits = WIDTH'(sel[SLICE-1:0] & slice_mask) << shamt;
    end

    // Next-state and register updates for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        nb_d     = nb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        valid_d  = valid_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_minuend;
                    nb_d    = ~i_subtrahend;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d  = (diff_q & ~put_mask) | put_bits;
                carry_d = cout;
                if (is_last) begin
                    borrow_d = ~cout;
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            nb_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = valid_q;
    assign o_diff   = diff_q;
    assign o_borrow = borrow_q;

endmodule

// File: tb/tb_csa_sub_43bit_seq.sv
// Randomized self-checking bench for csa_sub_43bit_seq against a plain-arithmetic model.

module tb_csa_sub_43bit_seq;

    localparam int W = 43;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         out_valid;
    logic         in_ready;
    logic [W-1:0] diff;
    logic         borrow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    csa_sub_43bit_seq dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (in_valid),
        .o_ready      (out_ready),
        .i_minuend    (minuend),
        .i_subtrahend (subtrahend),
        .o_valid      (out_valid),
        .i_ready      (in_ready),
        .o_diff       (diff),
        .o_borrow     (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned difference modulo 2^W, borrow when A < B.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] d;
        d = {21'b0, a} - {21'b0, b};
        return d[W-1:0];
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b);
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Wait (bounded) on a falling edge for o_ready, present operands, let the accept edge pass.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_accept", {63'b0, out_ready}, 64'd1);
        in_valid   = 1'b1;
        minuend    = a;
        subtrahend = b;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        minuend    = rand_op();
        subtrahend = rand_op();
    endtask

    // Count edges from accept to o_valid; expects exactly 11 with o_ready low throughout.
    task automatic wait_result(input string tag);
        int  n;
        bit  ready_seen;
        n = 0;
        ready_seen = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_ready) ready_seen = 1;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'd11);
        check_eq({tag, "_ready_low"}, {63'b0, ready_seen}, 64'd0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        check_eq({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
        check_eq({tag, "_diff"}, {21'b0, diff}, {21'b0, ref_diff(a, b)});
        check_eq({tag, "_borrow"}, {63'b0, borrow}, {63'b0, ref_borrow(a, b)});
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, {63'b0, out_valid}, 64'd0);
        check_eq({tag, "_ready_back"}, {63'b0, out_ready}, 64'd1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(a, b);
        wait_result(tag);
        check_result(tag, a, b);
        handshake(tag);
    endtask

    initial begin
        logic [W-1:0] a, b, na, nb;
        logic [W-1:0] held_diff;
        logic         held_borrow;
        int           last_acc;
        int           n;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_ready   = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        #2;
        check_eq("rst_valid", {63'b0, out_valid}, 64'd0);
        check_eq("rst_ready", {63'b0, out_ready}, 64'd1);
        check_eq("rst_diff", {21'b0, diff}, 64'd0);
        check_eq("rst_borrow", {63'b0, borrow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, including full borrow ripple and narrow top slice.
        full_op("t1", 43'd100, 43'd1);
        check_eq("t1_const", {21'b0, ref_diff(43'd100, 43'd1)}, 64'h63);
        full_op("t2", 43'd0, 43'd1);
        full_op("t3a", 43'h400_0000_0000, 43'd1);
        full_op("t3b", 43'h555_5555_5555, 43'h555_5555_5555);

        // Back-pressure: result holds while new operands are offered and ignored.
        a = rand_op();
        b = rand_op();
        start_op(a, b);
        wait_result("t4");
        held_diff   = diff;
        held_borrow = borrow;
        check_result("t4", a, b);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = (i % 2 == 0);
            minuend    = rand_op();
            subtrahend = rand_op();
            @(posedge clk);
            #1;
            check_eq("t4_hold_valid", {63'b0, out_valid}, 64'd1);
            check_eq("t4_hold_diff", {21'b0, diff}, {21'b0, held_diff});
            check_eq("t4_hold_borrow", {63'b0, borrow}, {63'b0, held_borrow});
            check_eq("t4_hold_ready", {63'b0, out_ready}, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("t4");
        @(posedge clk);
        #1;
        check_eq("t4_no_queue", {63'b0, out_valid}, 64'd0);

        // Asynchronous reset in the middle of RUN.
        start_op(43'h7ff_ffff_ffff, 43'h123_4567_89ab);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", {63'b0, out_valid}, 64'd0);
        check_eq("t5_rst_diff", {21'b0, diff}, 64'd0);
        check_eq("t5_rst_borrow", {63'b0, borrow}, 64'd0);
        check_eq("t5_rst_ready", {63'b0, out_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        full_op("t5", 43'd7, 43'd9);

        // Streaming with both handshakes tied high: 13-cycle accept spacing.
        @(negedge clk);
        in_valid = 1'b1;
        in_ready = 1'b1;
        last_acc = -1;
        for (int k = 0; k < 20; k++) begin
            na = rand_op();
            nb = rand_op();
            if (k % 5 == 0) nb = na + 43'd1;
            n = 0;
            while (!out_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            check_eq("t6_ready", {63'b0, out_ready}, 64'd1);
            minuend    = na;
            subtrahend = nb;
            if (last_acc >= 0) check_eq("t6_spacing", 64'(cyc - last_acc), 64'd13);
            last_acc = cyc;
            @(posedge clk);
            #1;
            minuend    = rand_op();
            subtrahend = rand_op();
            wait_result("t6");
            check_result("t6", na, nb);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_sub_43bit_seq.md
Name: csa_sub_43bit_seq

Overview:
- Multicycle 43-bit subtractor (A − B), the inverse-direction companion to the combinational carry-select adder datapath.
- Processes one 4-bit carry-select slice per clock, with the top slice narrower when WIDTH is not a multiple of SLICE.
- Sits between a valid/ready producer and consumer wherever area matters more than latency.
- Reports difference and borrow-out.

Parameters:
- WIDTH, 43, operand/result width in bits; must be ≥ SLICE+1.
- SLICE, 4, bits processed per cycle; legal range 2..8.
- Derived, not overridable: NSLICE = ceil(WIDTH/SLICE) = 11 and LAST_W = WIDTH − (NSLICE−1)·SLICE = 3.

Ports:
- i_clk  input  1  sole clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operands present.
- o_ready  output  1  block can accept operands.
- i_minuend  input  WIDTH  A.
- i_subtrahend  input  WIDTH  B.
- o_valid  output  1  result present.
- i_ready  input  1  consumer takes result.
- o_diff  output  WIDTH  (A − B) mod 2^WIDTH.
- o_borrow  output  1  1 when A < B, unsigned.

Behaviour:
- Reset: i_rst_n low forces the following immediately, independent of the clock:
  - state = IDLE, o_valid = 0, o_diff = 0, o_borrow = 0;
  - slice index = 0, carry register = 1, operand registers = 0.
  - o_ready = 1 once state is IDLE.
  - Reset mid-RUN or mid-DONE aborts the operation; no partial result survives.
- o_ready = (state == IDLE), decoded purely from registered state with no combinational path from i_valid or i_ready.
- FSM:
  - IDLE: on i_valid & o_ready at an edge, capture A and ~B into operand registers, set carry = 1, index = 0, go to RUN.
  - RUN: each edge, compute slice `index` (width SLICE, or LAST_W for the last slice):
    - form sum0 = a_s + nb_s + 0 and sum1 = a_s + nb_s + 1 in parallel;
    - select with the stored carry and write the selected bits into o_diff[slice];
    - update carry from the selected slice carry-out;
    - index++.
  - RUN exit: on the edge that completes slice NSLICE−1, set o_borrow = ~final carry and o_valid = 1, go to DONE.
  - DONE: o_valid, o_diff and o_borrow stay stable until i_ready & o_valid at an edge. That edge clears o_valid and returns to IDLE. o_diff and o_borrow hold their last values and are don't-care while o_valid = 0.
- Latency: o_valid rises exactly NSLICE (11) edges after the accept edge.
- Throughput: one operation per NSLICE+2 cycles minimum. There is no accept in the same cycle as result hand-off; o_ready rises the cycle after the DONE handshake.
- Input changes after the accept edge are ignored. i_valid while not IDLE is ignored and not queued.
- o_diff bits of not-yet-computed slices are unspecified during RUN. Only the value qualified by o_valid is checked.
- Arithmetic: two's-complement A + ~B + 1 truncated to WIDTH; borrow = ~carry-out of the MSB slice.
- No X on any output after reset release; i_ready high while o_valid = 0 has no effect.

Test Plan:
1. Accept A=100, B=1 → exactly 11 edges later o_valid=1, o_diff=0x00000000063, o_borrow=0; o_ready=0 throughout RUN/DONE.
2. A=0, B=1 → o_diff=0x7FFFFFFFFFF, o_borrow=1 (borrow ripples through every slice including the 3-bit top slice).
3. A=0x40000000000, B=0x00000000001 → o_diff=0x3FFFFFFFFFF, o_borrow=0. A=B=0x55555555555 → o_diff=0, o_borrow=0.
4. Result pending with i_ready=0 for 5 cycles, i_valid pulsed with new operands meanwhile → o_valid, o_diff, o_borrow stable, o_ready=0, new operands ignored. Then i_ready=1 → o_valid=0 next edge, o_ready=1.
5. Assert i_rst_n low asynchronously during RUN at index 5 → o_valid=0, o_diff=0, o_borrow=0 without a clock edge. After release, A=7, B=9 → o_diff=0x7FFFFFFFFFE, o_borrow=1 after 11 edges.
6. i_valid and i_ready tied high, 20 random operand pairs → each result matches a golden (A−B) mod 2^43 and borrow; accepts spaced exactly 13 cycles apart.
